cordic_arg_reduce_ctrl: RTL and testbench

- Upstream front-end of the CORDIC sine/cosine engine FSM.
- Accepts a fixed-point radian angle and an operation request, then reduces the angle to [0, pi/2) and derives the 2-bit quadrant used as shift_region_flag.
- Launches the CORDIC FSM, captures its result, acknowledges it, and holds the result for the downstream consumer under a valid/ack handshake.

---
 rtl/cordic_arg_reduce_ctrl.sv | 128 ++++++++++++
 tb/tb_cordic_arg_reduce_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/cordic_arg_reduce_ctrl.sv
// Front-end controller for the CORDIC sine/cosine engine: reduces a Q3.(W-3) angle
// to [0, pi/2) plus a quadrant, launches the CORDIC FSM and hands its result downstream.
module cordic_arg_reduce_ctrl #(
    parameter int              W       = 32,
    parameter int              RW      = 32,
    parameter logic [W-1:0]    HALF_PI = 32'h3243F6A9,
    parameter logic [W-1:0]    TWO_PI  = 32'hC90FDAA2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          beg_in,
    input  logic          operation_in,
    input  logic [W-1:0]  angle_in,
    output logic          busy,
    output logic          beg_FSM_CORDIC,
    output logic          operation,
    output logic [1:0]    shift_region_flag,
    output logic [W-1:0]  angle_red,
    input  logic          ready_CORDIC,
    input  logic [RW-1:0] result_in,
    output logic          ACK_FSM_CORDIC,
    output logic          valid_out,
    output logic [RW-1:0] data_out,
    input  logic          ack_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRAP,
        S_QUAD,
        S_LAUNCH,
        S_WAIT,
        S_ACK,
        S_HOLD
    } state_t;

    state_t        state_reg, state_next;
    logic [W-1:0]  r_reg, r_next;
    logic [1:0]    q_reg, q_next;
    logic          op_reg, op_next;
    logic [RW-1:0] data_reg, data_next;
    logic          valid_reg, valid_next;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            r_reg     <= '0;
            q_reg     <= '0;
            op_reg    <= 1'b0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            r_reg     <= r_next;
            q_reg     <= q_next;
            op_reg    <= op_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        r_next     = r_reg;
        q_next     = q_reg;
        op_next    = op_reg;
        data_next  = data_reg;
        valid_next = valid_reg;
        case (state_reg)
            S_IDLE: begin
                if (beg_in) begin
                    r_next     = angle_in;
                    op_next    = operation_in;
                    q_next     = '0;
                    state_next = S_WRAP;
                end
            end
            S_WRAP: begin
                // Inputs are below 8 < 4*pi, so a single 2*pi subtraction always suffices.
                if (r_reg >= TWO_PI) begin
                    r_next = r_reg - TWO_PI;
                end
                state_next = S_QUAD;
            end
            S_QUAD: begin
                if (r_reg >= HALF_PI) begin
                    r_next = r_reg - HALF_PI;
                    q_next = q_reg + 2'd1;
                end else begin
                    state_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (ready_CORDIC) begin
                    data_next  = result_in;
                    state_next = S_ACK;
                end
            end
            S_ACK: begin
                valid_next = 1'b1;
                state_next = S_HOLD;
            end
            S_HOLD: begin
                // A beg_in coinciding with ack_out is dropped; IDLE samples it afresh.
                if (ack_out) begin
                    valid_next = 1'b0;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign busy              = (state_reg != S_IDLE);
    assign beg_FSM_CORDIC    = (state_reg == S_LAUNCH);
    assign ACK_FSM_CORDIC    = (state_reg == S_ACK);
    assign operation         = op_reg;
    assign shift_region_flag = q_reg;
    assign angle_red         = r_reg;
    assign valid_out         = valid_reg;
    assign data_out          = data_reg;

endmodule

// File: tb/tb_cordic_arg_reduce_ctrl.sv
// Directed bench for cordic_arg_reduce_ctrl with a behavioural CORDIC responder and consumer.
module tb_cordic_arg_reduce_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        beg_in = 1'b0;
    logic        operation_in = 1'b0;
    logic [31:0] angle_in = '0;
    logic        busy;
    logic        beg_FSM_CORDIC;
    logic        operation;
    logic [1:0]  shift_region_flag;
    logic [31:0] angle_red;
    logic        ready_CORDIC = 1'b0;
    logic [31:0] result_in = '0;
    logic        ACK_FSM_CORDIC;
    logic        valid_out;
    logic [31:0] data_out;
    logic        ack_out = 1'b0;

    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;

    cordic_arg_reduce_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .beg_in            (beg_in),
        .operation_in      (operation_in),
        .angle_in          (angle_in),
        .busy              (busy),
        .beg_FSM_CORDIC    (beg_FSM_CORDIC),
        .operation         (operation),
        .shift_region_flag (shift_region_flag),
        .angle_red         (angle_red),
        .ready_CORDIC      (ready_CORDIC),
        .result_in         (result_in),
        .ACK_FSM_CORDIC    (ACK_FSM_CORDIC),
        .valid_out         (valid_out),
        .data_out          (data_out),
        .ack_out           (ack_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ACK_FSM_CORDIC) ack_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a request and run to the LAUNCH cycle, checking latency and reduction.
    task automatic launch_req(input logic [31:0] ang, input logic op,
                              input logic [31:0] exp_red, input logic [1:0] exp_q,
                              input int exp_lat);
        int n;
        angle_in     = ang;
        operation_in = op;
        beg_in       = 1'b1;
        tick();
        beg_in       = 1'b0;
        angle_in     = 32'hFFFF_FFFF;
        operation_in = ~op;
        n = 0;
        while (!beg_FSM_CORDIC && n < 20) begin
            tick();
            n++;
        end
        chk("launch_latency", 64'(n), 64'(exp_lat));
        chk("launch_pulse", 64'(beg_FSM_CORDIC), 64'd1);
        chk("angle_red", 64'(angle_red), 64'(exp_red));
        chk("quadrant", 64'(shift_region_flag), 64'(exp_q));
        chk("operation", 64'(operation), 64'(op));
        chk("busy_launch", 64'(busy), 64'd1);
        $display("req angle=%h op=%0d lat=%0d red=%h q=%0d", ang, op, n, angle_red, shift_region_flag);
    endtask

    // Serve the CORDIC handshake, then hold the result under a delayed consumer ack.
    task automatic finish_req(input int delay, input logic [31:0] res,
                              input logic [31:0] exp_red, input logic [1:0] exp_q, input logic op,
                              input int hold_n, input logic beg_in_hold, input logic beg_with_ack);
        int a0;
        a0 = ack_cnt;
        if (delay == 0) begin
            ready_CORDIC = 1'b1;
            result_in    = res;
        end
        tick();
        chk("launch_one_cycle", 64'(beg_FSM_CORDIC), 64'd0);
        for (int i = 1; i < delay; i++) begin
            tick();
        end
        chk("no_ack_in_wait", 64'(ack_cnt), 64'(a0));
        ready_CORDIC = 1'b1;
        result_in    = res;
        tick();
        ready_CORDIC = 1'b0;
        result_in    = 32'hDEAD_BEEF;
        chk("ack_pulse", 64'(ACK_FSM_CORDIC), 64'd1);
        chk("valid_early", 64'(valid_out), 64'd0);
        chk("data_capture", 64'(data_out), 64'(res));
        tick();
        chk("ack_one_cycle", 64'(ACK_FSM_CORDIC), 64'd0);
        chk("valid_high", 64'(valid_out), 64'd1);
        chk("ack_count", 64'(ack_cnt), 64'(a0 + 1));
        for (int i = 0; i < hold_n; i++) begin
            if (beg_in_hold && i == hold_n / 2) beg_in = 1'b1;
            tick();
            beg_in = 1'b0;
            chk("hold_valid", 64'(valid_out), 64'd1);
            chk("hold_data", 64'(data_out), 64'(res));
            chk("hold_state", {31'd0, busy, operation, 29'd0, shift_region_flag, angle_red},
                {31'd0, 1'b1, op, 29'd0, exp_q, exp_red});
        end
        beg_in  = beg_with_ack;
        ack_out = 1'b1;
        tick();
        ack_out = 1'b0;
        beg_in  = 1'b0;
        chk("valid_cleared", 64'(valid_out), 64'd0);
        chk("idle_after_ack", 64'(busy), 64'd0);
        tick();
        chk("stray_beg_ignored", 64'(busy), 64'd0);
        $display("done result=%h data_out=%h acks=%0d", res, data_out, ack_cnt - a0);
    endtask

    initial begin
        int a0;
        reset = 1'b0;
        tick();
        tick();
        chk("rst_outputs", {busy, beg_FSM_CORDIC, ACK_FSM_CORDIC, valid_out, operation, shift_region_flag},
            7'd0);
        chk("rst_angle_red", 64'(angle_red), 64'd0);
        chk("rst_data_out", 64'(data_out), 64'd0);
        $display("reset outputs busy=%0d valid=%0d", busy, valid_out);
        reset = 1'b1;
        tick();

        launch_req(32'h3243F6A8, 1'b0, 32'h3243F6A8, 2'd0, 2);
        finish_req(40, 32'h3F3504F3, 32'h3243F6A8, 2'd0, 1'b0, 10, 1'b1, 1'b0);

        // 5.0 rad: three quarter-turn subtractions, 0xA0000000 - 3*0x3243F6A9
        launch_req(32'hA000_0000, 1'b1, 32'h0934_1C05, 2'd3, 5);
        finish_req(0, 32'h3F80_0000, 32'h0934_1C05, 2'd3, 1'b1, 2, 1'b0, 1'b0);

        launch_req(32'hE000_0000, 1'b0, 32'h16F0_255E, 2'd0, 2);
        finish_req(3, 32'hBF00_0000, 32'h16F0_255E, 2'd0, 1'b0, 1, 1'b0, 1'b1);

        launch_req(32'hC90F_DAA2, 1'b1, 32'h0000_0000, 2'd0, 2);
        finish_req(5, 32'h0000_0000, 32'h0000_0000, 2'd0, 1'b1, 1, 1'b0, 1'b0);

        launch_req(32'h3243_F6A9, 1'b0, 32'h0000_0000, 2'd1, 3);
        finish_req(2, 32'h3F7F_FFFF, 32'h0000_0000, 2'd1, 1'b0, 1, 1'b0, 1'b0);

        // Reset held two cycles while waiting on the CORDIC engine.
        launch_req(32'h1000_0000, 1'b1, 32'h1000_0000, 2'd0, 2);
        tick();
        a0 = ack_cnt;
        reset = 1'b0;
        tick();
        tick();
        chk("midrst_outputs", {busy, beg_FSM_CORDIC, ACK_FSM_CORDIC, valid_out, operation, shift_region_flag},
            7'd0);
        chk("midrst_angle_red", 64'(angle_red), 64'd0);
        chk("midrst_data_out", 64'(data_out), 64'd0);
        reset = 1'b1;
        ready_CORDIC = 1'b1;
        result_in = 32'h1234_5678;
        tick();
        ready_CORDIC = 1'b0;
        chk("midrst_idle", 64'(busy), 64'd0);
        chk("midrst_no_ack", 64'(ack_cnt), 64'(a0));
        chk("midrst_no_capture", 64'(data_out), 64'd0);
        $display("mid-WAIT reset busy=%0d acks=%0d", busy, ack_cnt - a0);

        launch_req(32'h0000_0000, 1'b1, 32'h0000_0000, 2'd0, 2);
        finish_req(4, 32'h3E80_0000, 32'h0000_0000, 2'd0, 1'b1, 2, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
